// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         DEF_TIMEOUT = 64;
  localparam int         DEF_CNT_W   = 32;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign count = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: memory freeze > branch flush > load-use stall, plus a
// memory-wait watchdog that parks the pipeline in HALT until reset.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int              WC_W  = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO_V  = WC_W'(TIMEOUT);
  localparam logic [WC_W-1:0] ONE_V = WC_W'(1);

  state_e          r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_mem_timeout;

  logic            w_freeze;
  logic            w_active;
  logic            w_loaduse;
  logic            w_branch;
  logic            w_stall;
  logic            w_stall_inc;
  logic [WC_W-1:0] w_wait_nxt;

  assign w_freeze = ((r_state == RUN) && dmem_req && !dmem_ready) ||
                    ((r_state == MEM_WAIT) && !dmem_ready);

  // The release cycle of MEM_WAIT behaves exactly like RUN.
  assign w_active = !rst && (r_state != HALT) && !w_freeze;

  assign w_loaduse = idex_memread && (idex_rt != REG_ZERO) &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  assign w_branch = w_active && exmem_branch_taken;
  assign w_stall  = w_active && !exmem_branch_taken && w_loaduse;

  assign pc_write    = w_active && !w_stall;
  assign ifid_write  = w_active && !w_stall;
  assign idex_write  = w_active;
  assign exmem_write = w_active;
  assign memwb_write = w_active;
  assign ifid_flush  = w_branch;
  assign idex_flush  = w_branch || w_stall;
  assign exmem_flush = w_branch;

  assign halted      = (r_state == HALT);
  assign mem_timeout = r_mem_timeout;

  assign w_wait_nxt  = r_wait_cnt + ONE_V;
  assign w_stall_inc = (r_state != HALT) && !pc_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= ONE_V;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_wait_nxt;
            // wait_cnt counts frozen cycles; TIMEOUT of them trips the watchdog.
            if (w_wait_nxt == TO_V) begin
              r_state       <= HALT;
              r_mem_timeout <= 1'b1;
            end
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .clear (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_branch),
    .clear (1'b0),
    .count (flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios then randomized traffic against a rule-level model.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ifid_rs, ifid_rt, idex_rt;
  logic          ifid_uses_rt, idex_memread, exmem_branch_taken, dmem_req, dmem_ready;
  logic          pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic          ifid_flush, idex_flush, exmem_flush, halted, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .ifid_rs            (ifid_rs),
    .ifid_rt            (ifid_rt),
    .ifid_uses_rt       (ifid_uses_rt),
    .idex_memread       (idex_memread),
    .idex_rt            (idex_rt),
    .exmem_branch_taken (exmem_branch_taken),
    .dmem_req           (dmem_req),
    .dmem_ready         (dmem_ready),
    .pc_write           (pc_write),
    .ifid_write         (ifid_write),
    .idex_write         (idex_write),
    .exmem_write        (exmem_write),
    .memwb_write        (memwb_write),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .exmem_flush        (exmem_flush),
    .halted             (halted),
    .mem_timeout        (mem_timeout),
    .stall_count        (stall_count),
    .flush_count        (flush_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: mode 0=running, 1=waiting on memory, 2=halted.
  int m_mode, m_waited, m_stall, m_flush;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_vec();
    return {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
            ifid_flush, idex_flush, exmem_flush, halted, mem_timeout};
  endfunction

  task automatic idle_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = 5'd0;
    exmem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle(input string tag);
    bit lu, frz;
    logic [9:0] e;
    #1;
    lu  = idex_memread && (idex_rt != 0) &&
          (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    frz = (m_mode == 0 && dmem_req && !dmem_ready) || (m_mode == 1 && !dmem_ready);
    if (m_mode == 2)             e = {8'b0, 1'b1, m_to};
    else if (frz)                e = {8'b0, 1'b0, m_to};
    else if (exmem_branch_taken) e = {5'b11111, 3'b111, 1'b0, m_to};
    else if (lu)                 e = {5'b00111, 3'b010, 1'b0, m_to};
    else                         e = {5'b11111, 3'b000, 1'b0, m_to};
    check({tag, ".ctrl"}, 32'(ctrl_vec()), 32'(e));
    check({tag, ".stall"}, 32'(stall_count), 32'(m_stall));
    check({tag, ".flush"}, 32'(flush_count), 32'(m_flush));
    @(posedge clk);
    if (m_mode != 2) begin
      if (frz) begin
        m_waited = (m_mode == 0) ? 1 : m_waited + 1;
        m_mode   = 1;
        if (m_waited == TO) begin
          m_mode = 2;
          m_to   = 1'b1;
        end
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end else begin
        m_mode   = 0;
        m_waited = 0;
        if (exmem_branch_taken)  m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (lu)             m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
    end
    @(negedge clk);
  endtask

  // Asserts rst between edges; outputs must drop without waiting for a clock.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, ".rst_ctrl"}, 32'(ctrl_vec()), 32'd0);
    check({tag, ".rst_cnt"}, 32'({stall_count, flush_count}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_to = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_to = 1'b0;
    @(negedge clk);
    do_reset("init");
    cycle("idle");

    // Reset arriving while a stall is being requested.
    idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
    cycle("pre_rst");
    do_reset("mid");
    idle_inputs();
    cycle("post_rst");

    // Load-use hit, then the same pattern on r0.
    do_reset("lu");
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    cycle("lu");
    idle_inputs();
    cycle("lu_after");
    check("lu.count", 32'(stall_count), 32'd1);
    idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    cycle("lu_r0");
    check("lu_r0.count", 32'(stall_count), 32'd1);
    idex_rt = 5'd9; ifid_rs = 5'd1; ifid_rt = 5'd9; ifid_uses_rt = 1'b1;
    cycle("lu_rt");

    // Branch overrides a concurrent load-use hazard.
    do_reset("br");
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; exmem_branch_taken = 1'b1;
    cycle("br_lu");
    idle_inputs();
    cycle("br_after");
    check("br.flush", 32'(flush_count), 32'd1);
    check("br.stall", 32'(stall_count), 32'd0);

    // Three frozen cycles then release.
    do_reset("frz");
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (3) cycle("frz");
    dmem_ready = 1'b1;
    cycle("frz_rel");
    idle_inputs();
    cycle("frz_after");
    check("frz.stall", 32'(stall_count), 32'd3);

    // Branch held under a freeze flushes only on release.
    do_reset("frzbr");
    dmem_req = 1'b1; dmem_ready = 1'b0; exmem_branch_taken = 1'b1;
    repeat (2) cycle("frzbr");
    dmem_ready = 1'b1;
    cycle("frzbr_rel");
    idle_inputs();
    cycle("frzbr_after");
    check("frzbr.flush", 32'(flush_count), 32'd1);

    // Watchdog: TO frozen cycles, then stuck in HALT regardless of inputs.
    do_reset("to");
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (TO) cycle("to_wait");
    check("to.halted", 32'(halted), 32'd1);
    check("to.timeout", 32'(mem_timeout), 32'd1);
    dmem_ready = 1'b1; exmem_branch_taken = 1'b1;
    repeat (3) cycle("to_halt");
    check("to.sticky", 32'({halted, mem_timeout}), 32'd3);

    // Randomized traffic; small register range makes hazards frequent.
    do_reset("rnd");
    for (int i = 0; i < 1500; i++) begin
      ifid_rs            = 5'($urandom_range(0, 3));
      ifid_rt            = 5'($urandom_range(0, 3));
      idex_rt            = 5'($urandom_range(0, 3));
      ifid_uses_rt       = 1'($urandom_range(0, 1));
      idex_memread       = 1'($urandom_range(0, 1));
      exmem_branch_taken = ($urandom_range(0, 4) == 0);
      dmem_req           = ($urandom_range(0, 3) == 0);
      dmem_ready         = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC.
- Detects load-use hazards and taken branches, and freezes the pipeline while data memory is not ready.
- Drives per-stage write-enable and flush (bubble) controls; the stage registers gain write/flush inputs driven from here.
- Adds a memory-wait watchdog and performance counters.

Parameters:
TIMEOUT, 64, max consecutive MEM_WAIT cycles before halting (>=2)
CNT_W, 32, width of stall/flush performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
ifid_rs  in  5  rs field of instruction in IF_ID
ifid_rt  in  5  rt field of instruction in IF_ID
ifid_uses_rt  in  1  decoded ID instruction reads rt as a source
idex_memread  in  1  MemRead of instruction in ID_EX
idex_rt  in  5  rt (ins20_16) of instruction in ID_EX
exmem_branch_taken  in  1  branch in EX_MEM resolved taken
dmem_req  in  1  EX_MEM instruction accesses data memory this cycle
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF_ID load enable
idex_write  out  1  ID_EX load enable
exmem_write  out  1  EX_MEM load enable
memwb_write  out  1  MEM_WB load enable
ifid_flush  out  1  IF_ID loads NOP on next edge
idex_flush  out  1  ID_EX loads all-zero controls on next edge
exmem_flush  out  1  EX_MEM loads all-zero controls on next edge
halted  out  1  controller in HALT
mem_timeout  out  1  sticky watchdog error
stall_count  out  CNT_W  cycles with any freeze or load-use stall
flush_count  out  CNT_W  branch flush events

Behaviour:
- All control outputs are combinational from current state and inputs, so they take effect at the very next clock edge. State, watchdog and counters are registered.
- Reset (async): state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0, flush_count=0. While rst=1, all *_write=0 and all *_flush=0.
- Default in RUN: all *_write=1, all *_flush=0.
- FSM states: RUN, MEM_WAIT, HALT.
- Priority (RUN): memory freeze > branch flush > load-use stall.
- Memory freeze:
  - Condition: dmem_req=1 && dmem_ready=0.
  - All five write enables=0 and flushes=0 this cycle.
  - Next state MEM_WAIT, wait_cnt=1.
  - If dmem_req && dmem_ready in the same cycle, there is no freeze.
- MEM_WAIT:
  - All writes=0 while dmem_ready=0; wait_cnt increments each cycle.
  - When wait_cnt reaches TIMEOUT with dmem_ready=0: next state HALT, mem_timeout<=1.
  - Cycle with dmem_ready=1: outputs evaluated exactly as in RUN, ignoring dmem_req. Next state RUN, wait_cnt=0.
  - A branch held in the frozen EX_MEM therefore flushes on the release cycle.
- Branch flush:
  - Condition: exmem_branch_taken=1 and no freeze.
  - ifid_flush=idex_flush=exmem_flush=1, pc_write=1, ifid_write=1.
  - Any simultaneous load-use stall is suppressed.
  - flush_count +1.
- Load-use stall:
  - Hazard condition: idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
  - Response: pc_write=0, ifid_write=0, idex_flush=1; other writes=1. Lasts exactly one cycle, after which the bubble clears the hazard naturally.
- HALT: all writes=0, all flushes=0, halted=1. Exit only via rst.
- stall_count: +1 in each cycle where pc_write=0, excluding reset and HALT.
- Counters: saturate at all-ones, no wrap.
- rst asserted mid-MEM_WAIT: immediate return to RUN with counters cleared; the pending access is abandoned.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2)
  - REG_ZERO=5'd0
  - default TIMEOUT
- One sub-module: sat_counter (param width, inc, clear), instantiated twice for stall_count and flush_count.
- Hazard compare stays inline.

Test Plan:
- rst pulse mid-run (asynchronous, between edges) -> outputs immediately writes=0/flushes=0; after release all writes=1, counters 0.
- Load-use: idex_memread=1, idex_rt=5'd8, ifid_rs=5'd8 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_count=1. Repeat with idex_rt=0 -> no stall.
- Branch taken together with the load-use condition -> three flushes=1, pc_write=1, no stall; flush_count=1, stall_count unchanged.
- dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles all writes=0, release cycle writes=1; stall_count=3, state back to RUN.
- Freeze while exmem_branch_taken=1, ready after 2 cycles -> flushes asserted only on the release cycle; flush_count=1.
- TIMEOUT=4, dmem_ready held 0 -> HALT after 4 wait cycles, mem_timeout=1 and halted=1 sticky; ready/branch inputs are then ignored until rst.
